// File: rtl/cordic_atanh.sv
// Iterative hyperbolic CORDIC, vectoring mode: Z = atanh(X) for |X| <= LIMIT.
// One micro-rotation per clock, 18 steps with shifts 4 and 13 repeated.
//
// state  | meaning
// IDLE   | waiting for Start, no result held
// RUN    | one micro-rotation per cycle, cnt = step number 0..17
// ERANGE | out-of-range request, one settle cycle before FINISH
// FINISH | register Z / Err, raise Done
// DONE   | hold result until Rst or a new Start
module cordic_atanh #(
  parameter int WI  = 2,
  parameter int WF  = 16,
  parameter int WIO = 4,
  parameter int WFO = 16,
  parameter int G   = 4,
  parameter logic [WI+WF-1:0] LIMIT = 18'h0CCCC
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [WI+WF-1:0]     X,
  output logic [WIO+WFO-1:0]   Z,
  output logic                 Done,
  output logic                 Err
);

  localparam int WX    = WI + WF;
  localparam int WD    = WI + 1 + WF + G;
  localparam int WZ    = WIO + WFO + G;
  localparam int WO    = WIO + WFO;
  localparam int NSTEP = 18;

  localparam logic signed [WD-1:0] X_ONE  = {{WI{1'b0}}, 1'b1, {(WF+G){1'b0}}};
  localparam logic signed [WZ-1:0] Z_HALF = {{(WZ-G){1'b0}}, 1'b1, {(G-1){1'b0}}};
  localparam logic [WO-1:0]        Z_MAX  = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0]        Z_MIN  = {1'b1, {(WO-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RUN, ERANGE, FINISH, DONE} state_t;

  state_t state, state_nxt;

  logic [4:0]           cnt;
  logic signed [WD-1:0] x_r, y_r;
  logic signed [WZ-1:0] z_r;
  logic                 err_r, neg_r, zero_r;

  logic                 load, step, fin, clr;
  logic [WX:0]          x_sext, x_mag;
  logic                 range_bad;
  logic [4:0]           sh;
  logic signed [WD-1:0] x_shr, y_shr;
  logic signed [WZ-1:0] tab;
  logic [WO-1:0]        z_q;

  // Step number -> shift index: 1,2,3,4,4,5..13,13,14,15,16
  function automatic logic [4:0] shift_of(input logic [4:0] c);
    if (c < 5'd4)       shift_of = c + 5'd1;
    else if (c < 5'd14) shift_of = c;
    else                shift_of = c - 5'd1;
  endfunction

  // atanh(2^-i) rounded to 20 fraction bits
  function automatic logic signed [WZ-1:0] atanh_lut(input logic [4:0] i);
    case (i)
      5'd1:    atanh_lut = WZ'(24'h08C9F5);
      5'd2:    atanh_lut = WZ'(24'h04162C);
      5'd3:    atanh_lut = WZ'(24'h0202B1);
      5'd4:    atanh_lut = WZ'(24'h010056);
      5'd5:    atanh_lut = WZ'(24'h00800B);
      5'd6:    atanh_lut = WZ'(24'h004001);
      5'd7:    atanh_lut = WZ'(24'h002000);
      5'd8:    atanh_lut = WZ'(24'h001000);
      5'd9:    atanh_lut = WZ'(24'h000800);
      5'd10:   atanh_lut = WZ'(24'h000400);
      5'd11:   atanh_lut = WZ'(24'h000200);
      5'd12:   atanh_lut = WZ'(24'h000100);
      5'd13:   atanh_lut = WZ'(24'h000080);
      5'd14:   atanh_lut = WZ'(24'h000040);
      5'd15:   atanh_lut = WZ'(24'h000020);
      5'd16:   atanh_lut = WZ'(24'h000010);
      default: atanh_lut = '0;
    endcase
  endfunction

  // Range check on one extra bit so |0x20000| does not wrap back negative
  always_comb begin
    x_sext    = {X[WX-1], X};
    x_mag     = X[WX-1] ? (~x_sext + 1'b1) : x_sext;
    range_bad = (x_mag > {1'b0, LIMIT});
    sh        = shift_of(cnt);
    x_shr     = x_r >>> sh;
    y_shr     = y_r >>> sh;
    tab       = atanh_lut(sh);
    z_q       = WO'((z_r + Z_HALF) >>> G);
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load      = 1'b1;
          state_nxt = range_bad ? ERANGE : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == 5'(NSTEP - 1)) state_nxt = FINISH;
      end
      ERANGE: state_nxt = FINISH;
      FINISH: begin
        fin       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (Start) begin
          clr       = 1'b1;
          load      = 1'b1;
          state_nxt = range_bad ? ERANGE : RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load, micro-rotations, result register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      err_r  <= 1'b0;
      neg_r  <= 1'b0;
      zero_r <= 1'b0;
      Z      <= '0;
      Done   <= 1'b0;
      Err    <= 1'b0;
    end else begin
      if (clr) begin
        Done <= 1'b0;
        Err  <= 1'b0;
      end
      if (load) begin
        x_r    <= X_ONE;
        y_r    <= {X[WX-1], X, {G{1'b0}}};
        z_r    <= '0;
        cnt    <= '0;
        err_r  <= range_bad;
        neg_r  <= X[WX-1];
        zero_r <= (X == '0);
      end
      if (step) begin
        cnt <= cnt + 5'd1;
        if (y_r[WD-1]) begin
          x_r <= x_r + y_shr;
          y_r <= y_r + x_shr;
          z_r <= z_r - tab;
        end else begin
          x_r <= x_r - y_shr;
          y_r <= y_r - x_shr;
          z_r <= z_r + tab;
        end
      end
      // The iteration ends one LSB low for X=0, so a zero input is
      // forced to an exact zero result.
      if (fin) begin
        Done <= 1'b1;
        Err  <= err_r;
        if (err_r)       Z <= neg_r ? Z_MIN : Z_MAX;
        else if (zero_r) Z <= '0;
        else             Z <= z_q;
      end
    end
  end

endmodule
